spi_txn_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit SPI shift engine among several requesters, each owning its own active-low chip select.
- Accepts word requests, grants one at a time, and drives the chip select for the granted requester.
- Pulses the engine's start, waits for its completion, then enforces an inter-frame CS-high gap.
- Sits between the software/register-side requesters and the SPI serializer.

---
 rtl/spi_txn_arbiter.sv | 165 ++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter sharing one SPI shift engine among NUM_REQ chip selects.
// Optional WAIT-state watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        done,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [NUM_REQ-1:0]        cs_l,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      timeout
);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, GAP} state_t;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t                    state_q, state_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d, done_q, done_d, cs_l_q, cs_l_d;
  logic                      tx_start_q, tx_start_d, busy_q;
  logic [DATA_W-1:0]         tx_data_q, tx_data_d;
  logic [2:0]                grant_q, grant_d, ptr_q, ptr_d;
  logic [3:0]                gap_q, gap_d;
  logic                      found;
  logic [2:0]                win;
  int                        cand;
  logic [NUM_REQ*DATA_W-1:0] data_shift;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_hit, timeout_q, timeout_d;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  // Search starts one past the last grantee so every pending requester is served in turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && ((req >> cand) & ONE) != '0) begin
        found = 1'b1;
        win   = 3'(cand);
      end
    end
    data_shift = req_data >> (DATA_W * int'(win));
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    done_d     = '0;
    tx_start_d = 1'b0;
    cs_l_d     = cs_l_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    gap_d      = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          ack_d     = ONE << win;
          tx_data_d = data_shift[DATA_W-1:0];
          cs_l_d    = ~(ONE << win);
          grant_d   = win;
          ptr_d     = win;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        tx_start_d = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          cs_l_d  = '1;
          done_d  = ONE << grant_q;
          gap_d   = 4'(GAP_CYCLES - 1);
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_hit) begin
          cs_l_d    = '1;
          timeout_d = 1'b1;
          gap_d     = 4'(GAP_CYCLES - 1);
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
`endif
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      done_q     <= '0;
      cs_l_q     <= '1;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      ptr_q      <= 3'(NUM_REQ - 1);
      gap_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      cs_l_q     <= cs_l_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      busy_q     <= (state_d != IDLE);
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Held at zero outside WAIT, so it restarts from zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= (state_q == WAIT && state_d == WAIT) ? to_cnt_q + 1'b1 : '0;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign ack      = ack_q;
  assign done     = done_q;
  assign cs_l     = cs_l_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - directed self-checking bench for spi_txn_arbiter.
module tb_spi_txn_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  ack, done, cs_l;
  logic        tx_start, tx_done, busy, timeout;
  logic [15:0] tx_data;
  logic [2:0]  grant_id;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int cs_bad = 0;
  int excl_bad = 0;
  int to_seen = 0;

  spi_txn_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .cs_l(cs_l), .grant_id(grant_id), .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ($countones(~cs_l) > 1) cs_bad++;
    if ($countones({|ack, |done, tx_start, timeout}) > 1) excl_bad++;
    if (timeout) to_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(output int t);
    for (int i = 0; i < 40; i++) begin
      if (ack != 4'b0) break;
      tick();
    end
    check("ack_seen", {31'b0, |ack}, 32'd1);
    t = cyc;
  endtask

  task automatic do_frame(input int exp, input bit drop, input bit chk_gap);
    int t;
    logic [3:0] e1, ce;
    e1 = 4'b0001 << exp;
    ce = ~e1;
    wait_ack(t);
    check("ack_vec", ack, e1);
    check("grant_id", grant_id, exp);
    check("cs_l_grant", cs_l, ce);
    if (chk_gap) check("ack_after_done", t - last_done_cyc, 3);
    if (drop) req[exp] = 1'b0;
    tick();
    check("tx_start", tx_start, 1);
    repeat (4) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("done_vec", done, e1);
    check("cs_l_release", cs_l, 4'hF);
    last_done_cyc = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tx_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int t0;
    reset = 1'b1;
    req = '0;
    req_data = '0;
    tx_done = 1'b0;
    tick();
    tick();
    check("rst_cs_l", cs_l, 4'hF);
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant", grant_id, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;

    // Single frame with hand-checked latency and gap.
    req = 4'b0001;
    req_data[15:0] = 16'hA5C3;
    tick();
    check("t1_ack", ack, 4'b0001);
    check("t1_cs_l", cs_l, 4'b1110);
    check("t1_tx_data", tx_data, 16'hA5C3);
    check("t1_busy", busy, 1);
    check("t1_start_early", tx_start, 0);
    req = 4'b0000;
    tick();
    check("t1_tx_start", tx_start, 1);
    check("t1_ack_clear", ack, 0);
    repeat (19) tick();
    check("t1_cs_hold", cs_l, 4'b1110);
    check("t1_no_done", done, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t1_done", done, 4'b0001);
    check("t1_cs_release", cs_l, 4'b1111);
    check("t1_busy_gap", busy, 1);
    tick();
    check("t1_busy_gap2", busy, 1);
    tick();
    check("t1_busy_idle", busy, 0);

    // All requesters held high: rotation 0,1,2,3,0.
    do_reset();
    req_data = 64'h4444_3333_2222_1111;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      do_frame(k % 4, 1'b0, k > 0);
      if (k == 4) req = 4'b0000;
    end

    // Wrap-around: last grant 1, then requesters 0 and 1 both pending.
    do_reset();
    req = 4'b0010;
    do_frame(1, 1'b1, 1'b0);
    req = 4'b0011;
    do_frame(0, 1'b1, 1'b1);
    do_frame(1, 1'b1, 1'b1);
    repeat (3) tick();

    // tx_done in IDLE and SETUP is ignored.
    do_reset();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t4_idle_done", done, 0);
    check("t4_idle_busy", busy, 0);
    req = 4'b0100;
    tick();
    check("t4_ack", ack, 4'b0100);
    req = 4'b0000;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t4_tx_start", tx_start, 1);
    check("t4_setup_done", done, 0);
    repeat (3) tick();
    check("t4_wait_done", done, 0);
    check("t4_cs_hold", cs_l, 4'b1011);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t4_done", done, 4'b0100);
    repeat (3) tick();

    // Asynchronous reset in WAIT, then pointer restarts from requester 0.
    req = 4'b0100;
    wait_ack(t0);
    check("t5_ack", ack, 4'b0100);
    req = 4'b0000;
    tick();
    tick();
    check("t5_cs_wait", cs_l, 4'b1011);
    #2 reset = 1'b1;
    #1;
    check("t5_cs_async", cs_l, 4'b1111);
    check("t5_busy_async", busy, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t5_no_done", done, 0);
    tick();
    reset = 1'b0;
    req = 4'b0100;
    do_frame(2, 1'b1, 1'b0);
    repeat (3) tick();

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: no tx_done, pending requester 1 served after the gap.
    do_reset();
    req = 4'b0011;
    wait_ack(t0);
    check("to_ack", ack, 4'b0001);
    req = 4'b0010;
    tick();
    check("to_tx_start", tx_start, 1);
    t0 = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      t0++;
      if (timeout) break;
    end
    check("to_latency", t0, 64);
    check("to_cs_release", cs_l, 4'hF);
    check("to_no_done", done, 0);
    t0 = cyc;
    wait_ack(last_done_cyc);
    check("to_next_ack", ack, 4'b0010);
    check("to_next_lat", last_done_cyc - t0, 3);
    req = 4'b0000;
    tick();
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("to_next_done", done, 4'b0010);
    repeat (3) tick();
    check("to_pulses", to_seen, 1);
`else
    check("to_never", to_seen, 0);
`endif

    check("cs_onehot", cs_bad, 0);
    check("pulse_excl", excl_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
